// File: rtl/tft_lcd_rd_engine.sv
// Avalon-MM slave that runs one 8080-style read cycle on the TFT LCD bus per CTRL start.
// Optional interrupt output enabled by defining TFT_LCD_RD_IRQ_EN.
`timescale 1ns/1ps
module tft_lcd_rd_engine #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_RDL   = 8,
    parameter int unsigned T_RDH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] lcd_data_in,
    output logic              lcd_data_oe,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_rd_n,
    output logic              lcd_wr_n
`ifdef TFT_LCD_RD_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned MaxT12 = (T_SETUP > T_RDL) ? T_SETUP : T_RDL;
    localparam int unsigned MaxT   = (MaxT12 > T_RDH) ? MaxT12 : T_RDH;
    localparam int unsigned CntW   = $clog2(MaxT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              cs_n_q, rd_n_q, rs_q;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              busy, ctrl_wr, stat_wr, data_rd, start_req, start_ok, hold_exit;

    assign busy      = (state_q != StIdle);
    assign ctrl_wr   = chipselect & ~write_n & (address == 2'd1);
    assign stat_wr   = chipselect & ~write_n & (address == 2'd2);
    assign data_rd   = chipselect & ~read_n & (address == 2'd0);
    assign start_req = ctrl_wr & writedata[1];
    assign start_ok  = start_req & ~busy;
    assign hold_exit = (state_q == StHold) && (cnt_q == '0);

    // Completion wins over a simultaneous DATA read; a late start re-arms overrun.
    always_comb begin
        done_d = done_q;
        if (data_rd || start_ok) done_d = 1'b0;
        if (hold_exit)           done_d = 1'b1;
        overrun_d = overrun_q;
        if (stat_wr && writedata[2]) overrun_d = 1'b0;
        if (start_req && busy)       overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            rs_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            overrun_q <= overrun_d;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q <= StSetup;
                        cnt_q   <= CntW'(T_SETUP - 1);
                        cs_n_q  <= 1'b0;
                        rs_q    <= writedata[0];
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        state_q <= StStrobe;
                        cnt_q   <= CntW'(T_RDL - 1);
                        rd_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StStrobe: begin
                    // Sample on the same edge that raises nRD.
                    if (cnt_q == '0) begin
                        state_q <= StHold;
                        cnt_q   <= CntW'(T_RDH - 1);
                        rd_n_q  <= 1'b1;
                        data_q  <= lcd_data_in;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        cs_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TFT_LCD_RD_IRQ_EN
    logic ie_q, irq_q;
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= writedata[2];
            irq_q <= done_q & ie_q;
        end
    end

    assign irq = irq_q;
`else
    logic ie_q;
    logic unused_wdata;
    assign ie_q         = 1'b0;
    assign unused_wdata = ^writedata[31:2];
`endif

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0: readdata = 32'(data_q);
            2'd1: readdata = {29'b0, ie_q, busy, rs_q};
            2'd2: readdata = {29'b0, overrun_q, done_q, busy};
            default: readdata = '0;
        endcase
    end

    assign lcd_cs_n    = cs_n_q;
    assign lcd_rd_n    = rd_n_q;
    assign lcd_rs      = rs_q;
    assign lcd_wr_n    = 1'b1;
    assign lcd_data_oe = 1'b0;

endmodule

// File: tb/tb_tft_lcd_rd_engine.sv
// Self-checking bench for tft_lcd_rd_engine: scoreboard of expected DATA readbacks plus a
// negedge monitor of the panel strobes.
`timescale 1ns/1ps
module tb_tft_lcd_rd_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] lcd_data_in = '0;
    logic        lcd_data_oe, lcd_cs_n, lcd_rs, lcd_rd_n, lcd_wr_n;
`ifdef TFT_LCD_RD_IRQ_EN
    logic        irq;
`endif

    tft_lcd_rd_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .read_n      (read_n),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .lcd_data_in (lcd_data_in),
        .lcd_data_oe (lcd_data_oe),
        .lcd_cs_n    (lcd_cs_n),
        .lcd_rs      (lcd_rs),
        .lcd_rd_n    (lcd_rd_n),
        .lcd_wr_n    (lcd_wr_n)
`ifdef TFT_LCD_RD_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    int   cs_lo_cnt = 0, rd_lo_cnt = 0, rd_start = -1, rd_pulses = 0;
    logic rs_at_rd = 1'b0, rd_prev = 1'b1, oe_seen = 1'b0;

    always @(negedge clk) begin
        if (!lcd_rd_n && rd_prev) begin
            rd_pulses = rd_pulses + 1;
            rd_start  = cs_lo_cnt;
            rs_at_rd  = lcd_rs;
        end
        if (!lcd_cs_n) cs_lo_cnt = cs_lo_cnt + 1;
        if (!lcd_rd_n) rd_lo_cnt = rd_lo_cnt + 1;
        if (lcd_data_oe !== 1'b0) oe_seen = 1'b1;
        rd_prev = lcd_rd_n;
    end

    task automatic clear_mon();
        @(negedge clk);
        #2;
        cs_lo_cnt = 0; rd_lo_cnt = 0; rd_start = -1; rd_pulses = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic pop_exp(output logic [31:0] e);
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_cs_n, lcd_rd_n, lcd_wr_n, lcd_rs, lcd_data_oe} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_pins got=%b exp=11100",
                     {lcd_cs_n, lcd_rd_n, lcd_wr_n, lcd_rs, lcd_data_oe});
        end
        #2 reset_n = 1'b1;
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", got); end
        bus_read(2'd0, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", got); end
    endtask

    task automatic test_basic_read();
        clear_mon();
        lcd_data_in = 16'h9325;
        exp_q.push_back(32'h0000_9325);
        bus_write(2'd1, 32'h3);
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h1) begin failures++; $display("FAIL basic_busy got=%h exp=1", got); end
        repeat (16) @(negedge clk);
        checks++;
        if (cs_lo_cnt != 14) begin failures++; $display("FAIL basic_cs_len got=%0d exp=14", cs_lo_cnt); end
        checks++;
        if (rd_lo_cnt != 8) begin failures++; $display("FAIL basic_rd_len got=%0d exp=8", rd_lo_cnt); end
        checks++;
        if (rd_start != 2) begin failures++; $display("FAIL basic_rd_start got=%0d exp=2", rd_start); end
        checks++;
        if (rs_at_rd !== 1'b1) begin failures++; $display("FAIL basic_rs got=%b exp=1", rs_at_rd); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h2) begin failures++; $display("FAIL basic_done got=%h exp=2", got); end
        bus_read(2'd1, got);
        checks++;
        if (got !== 32'h1) begin failures++; $display("FAIL basic_ctrl got=%h exp=1", got); end
        bus_read(2'd0, got);
        pop_exp(exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_data got=%h exp=%h", got, exp); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL basic_done_clr got=%h exp=0", got); end
        checks++;
        if (lcd_rs !== 1'b1) begin failures++; $display("FAIL basic_rs_hold got=%b exp=1", lcd_rs); end
    endtask

    task automatic test_capture_edge();
        clear_mon();
        lcd_data_in = 16'h1111;
        exp_q.push_back(32'h0000_ABCD);
        bus_write(2'd1, 32'h2);
        repeat (9) @(negedge clk);
        checks++;
        if (lcd_rd_n !== 1'b0) begin failures++; $display("FAIL cap_in_strobe got=%b exp=0", lcd_rd_n); end
        lcd_data_in = 16'hABCD;
        @(negedge clk);
        checks++;
        if (lcd_rd_n !== 1'b1) begin failures++; $display("FAIL cap_rd_rise got=%b exp=1", lcd_rd_n); end
        repeat (8) @(negedge clk);
        checks++;
        if (rs_at_rd !== 1'b0) begin failures++; $display("FAIL cap_rs got=%b exp=0", rs_at_rd); end
        bus_read(2'd0, got);
        pop_exp(exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL cap_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_overrun();
        clear_mon();
        lcd_data_in = 16'h5A5A;
        exp_q.push_back(32'h0000_5A5A);
        bus_write(2'd1, 32'h2);
        repeat (2) @(negedge clk);
        bus_write(2'd1, 32'h2);
        repeat (16) @(negedge clk);
        checks++;
        if (rd_pulses != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", rd_pulses); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h6) begin failures++; $display("FAIL ovr_status got=%h exp=6", got); end
        bus_read(2'd0, got);
        pop_exp(exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL ovr_data got=%h exp=%h", got, exp); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h4) begin failures++; $display("FAIL ovr_sticky got=%h exp=4", got); end
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL ovr_clear got=%h exp=0", got); end
    endtask

    task automatic test_reset_mid_cycle();
        clear_mon();
        lcd_data_in = 16'h7777;
        bus_write(2'd1, 32'h3);
        repeat (4) @(negedge clk);
        checks++;
        if (lcd_rd_n !== 1'b0) begin failures++; $display("FAIL rst_in_strobe got=%b exp=0", lcd_rd_n); end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({lcd_cs_n, lcd_rd_n, lcd_rs} !== 3'b110) begin
            failures++;
            $display("FAIL rst_async got=%b exp=110", {lcd_cs_n, lcd_rd_n, lcd_rs});
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        bus_read(2'd0, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", got); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", got); end
        clear_mon();
        lcd_data_in = 16'h2468;
        exp_q.push_back(32'h0000_2468);
        bus_write(2'd1, 32'h2);
        repeat (16) @(negedge clk);
        checks++;
        if (cs_lo_cnt != 14) begin failures++; $display("FAIL rst_rerun_cs got=%0d exp=14", cs_lo_cnt); end
        bus_read(2'd0, got);
        pop_exp(exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_rerun_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ignored_writes();
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h1);
        bus_read(2'd0, got);
        checks++;
        if (got !== 32'h2468) begin failures++; $display("FAIL ign_data got=%h exp=2468", got); end
        bus_read(2'd3, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL ign_rsvd got=%h exp=0", got); end
        bus_read(2'd2, got);
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL ign_nostart got=%h exp=0", got); end
        checks++;
        if (oe_seen !== 1'b0 || lcd_wr_n !== 1'b1) begin
            failures++;
            $display("FAIL ign_oe_wr got=%b%b exp=01", oe_seen, lcd_wr_n);
        end
    endtask

`ifdef TFT_LCD_RD_IRQ_EN
    task automatic test_irq();
        int   done_at;
        logic irq_seen;
        clear_mon();
        lcd_data_in = 16'h0F0F;
        exp_q.push_back(32'h0000_0F0F);
        bus_write(2'd1, 32'h6);
        done_at = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            @(negedge clk);
            if (lcd_cs_n && cs_lo_cnt > 0) done_at = i;
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        bus_read(2'd0, got);
        pop_exp(exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL irq_data got=%h exp=%h", got, exp); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
        bus_write(2'd1, 32'h2);
        irq_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (irq) irq_seen = 1'b1;
        end
        checks++;
        if (irq_seen !== 1'b0) begin failures++; $display("FAIL irq_masked got=1 exp=0"); end
        bus_read(2'd0, got);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_capture_edge();
        test_overrun();
        test_reset_mid_cycle();
        test_ignored_writes();
`ifdef TFT_LCD_RD_IRQ_EN
        test_irq();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tft_lcd_rd_engine.md
Name: tft_lcd_rd_engine

Overview:
- Avalon-MM slave that runs complete 8080-style read cycles on the TFT LCD bus in hardware, for register/ID and GRAM readback.
- Software sets RS and writes a start bit. The block sequences nCS/nRS/nRD and samples the panel data bus at the nRD rising edge. Software then polls status and reads the result.
- Sits beside the existing LCD output PIOs on the same system bus. lcd_wr_n is held inactive throughout.

Parameters:
- DATA_W, 16, LCD data bus width (1..32); the sampled value is zero-extended into readdata.
- T_SETUP, 2, clk cycles with nCS low and RS valid before nRD falls (min 1).
- T_RDL, 8, clk cycles nRD is held low (min 1).
- T_RDH, 4, clk cycles after nRD rises before nCS releases (min 1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register select: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved
- chipselect  input  1  slave select
- read_n  input  1  active-low read strobe
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  combinational read mux, zero wait states
- lcd_data_in  input  DATA_W  panel data bus, input side of the external tristate
- lcd_data_oe  output  1  data bus output enable; 0 during any read cycle
- lcd_cs_n  output  1  panel chip select, active low
- lcd_rs  output  1  panel register/data select
- lcd_rd_n  output  1  panel read strobe, active low
- lcd_wr_n  output  1  constant 1

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low, ports named clk and reset_n.
- Reset values: lcd_cs_n=1, lcd_rd_n=1, lcd_wr_n=1, lcd_rs=0, lcd_data_oe=0, DATA=0, busy=0, done=0, overrun=0, FSM=IDLE.
- CTRL write (chipselect & ~write_n & address==1):
  - bit1=start, bit0=rs.
  - If IDLE and start=1: latch rs, clear done, enter SETUP on the next edge.
  - If start=0: no effect.
  - If busy and start=1: ignored, set overrun.
- FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE, with a single down-counter reloaded at each transition.
  - SETUP (T_SETUP cycles): cs_n=0, rs=latched, rd_n=1.
  - STROBE (T_RDL cycles): rd_n=0.
  - Last STROBE cycle: the edge leaving STROBE registers lcd_data_in into DATA, and rd_n rises on that same edge.
  - HOLD (T_RDH cycles): cs_n=0, rd_n=1.
  - Edge leaving HOLD: cs_n=1, busy=0, done=1.
- Timing:
  - busy is high exactly T_SETUP+T_RDL+T_RDH cycles, starting the cycle after the accepted CTRL write.
  - Defaults give 14 cycles; back-to-back starts give 15-cycle spacing.
- lcd_rs holds the latched value after the cycle; only the next accepted start changes it.
- lcd_data_oe is 0 whenever busy or IDLE. The block never drives the bus; lcd_data_oe stays 0 permanently (the output port exists so the top-level tristate wiring is uniform).
- Reads:
  - address 0: {zero-extend DATA}.
  - address 1: {30'b0, busy, rs}.
  - address 2: {29'b0, overrun, done, busy}.
  - address 3: 0.
- Read side effects:
  - A DATA read (chipselect & ~read_n & address==0) clears done.
  - If done is set on the same edge as a DATA read, set wins.
  - A STATUS write with bit2=1 clears overrun.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronous). No partial sample is kept.
- Writes to address 0 and 3 are ignored.

Optional Feature:
- Macro TFT_LCD_RD_IRQ_EN.
- When defined:
  - Adds output irq (1 bit).
  - CTRL bit2 is an interrupt-enable register (reset 0, written on every CTRL write).
  - irq = done & ie, registered.
  - CTRL readback bit2 shows ie.
- When undefined: no irq port, CTRL bit2 ignored and read as 0.

Test Plan:
- Reset, then idle: read STATUS -> 0. lcd_cs_n=1, lcd_rd_n=1, lcd_wr_n=1, lcd_rs=0.
- Write CTRL=0x3, lcd_data_in=0x9325 -> rs=1. cs_n low 14 cycles, rd_n low 8 cycles starting 2 cycles in. STATUS=0x2 after. DATA reads 0x00009325, then STATUS=0x0.
- Write CTRL=0x2 and change lcd_data_in from 0x1111 to 0xABCD during the last STROBE cycle -> the value on the exiting edge is captured. rs=0 throughout.
- Write CTRL=0x2 twice, 3 cycles apart -> second write ignored, overrun=1, only one nRD pulse. STATUS write 0x4 -> overrun=0.
- Pulse reset_n low during STROBE -> cs_n and rd_n go 1 without waiting for clk. DATA=0, busy=0. A new start then completes normally.
- With TFT_LCD_RD_IRQ_EN, CTRL=0x6 -> irq rises one cycle after done. Reading DATA drops irq the next cycle. With ie=0, irq never asserts.
